// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp encodings and the ID->EX control bundle.
package pipe_pkg;

    localparam int unsigned FUNCT_W    = 10;
    localparam int unsigned REG_ADDR_W = 5;

    // ALUOp values produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_LOAD_STORE = 2'b00,
        ALUOP_BRANCH     = 2'b01,
        ALUOP_RTYPE      = 2'b10,
        ALUOP_ITYPE      = 2'b11
    } aluop_e;

    // Control bundle: ALUOp plus five single-bit enables
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    localparam int unsigned CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t       CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline flop vector with async active-low reset, hold enable and sync clear.
// Ports: clk_i, rst_i (async, active-low), en_i (0 = hold), clr_i (load 0 when enabled),
//        d_i / q_o (W bits).
module pipe_field_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    // Hold wins over clear so a stalled stage keeps its contents
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= clr_i ? '0 : d_i;
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush and load-use bubble handling plus a
// saturating bubble counter.
// Ports: clk_i, rst_i (async, active-low); stall_i/flush_i/bubble_i (priority in that order);
//        control, operand, immediate, funct and register-address inputs (*_i) registered to
//        matching *_o outputs; valid_o (EX holds a real instruction); bubble_cnt_o.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  bubble_i,
    input  logic [1:0]            ALUOp_i,
    input  logic                  ALUSrc_i,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic                  RegWrite_i,
    input  logic                  MemtoReg_i,
    input  logic [DATA_W-1:0]     RS1data_i,
    input  logic [DATA_W-1:0]     RS2data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [FUNCT_W-1:0]    funct_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    input  logic [REG_ADDR_W-1:0] RDaddr_i,
    output logic [1:0]            ALUOp_o,
    output logic                  ALUSrc_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic                  RegWrite_o,
    output logic                  MemtoReg_o,
    output logic [DATA_W-1:0]     RS1data_o,
    output logic [DATA_W-1:0]     RS2data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [FUNCT_W-1:0]    funct_o,
    output logic [REG_ADDR_W-1:0] RS1addr_o,
    output logic [REG_ADDR_W-1:0] RS2addr_o,
    output logic [REG_ADDR_W-1:0] RDaddr_o,
    output logic                  valid_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    localparam int unsigned     CTRLV_W = CTRL_W + 1;
    localparam int unsigned     DATAG_W = 3 * DATA_W + FUNCT_W;
    localparam int unsigned     ADDRG_W = 3 * REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t                w_ctrl_d;
    ctrl_t                w_ctrl_q;
    logic [CTRLV_W-1:0]   w_ctrlv_q;
    logic [DATAG_W-1:0]   w_data_q;
    logic [ADDRG_W-1:0]   w_addr_q;
    logic                 w_load_en;
    logic                 w_ctrl_clr;
    logic                 w_bubble_evt;
    logic [CNT_W-1:0]     r_bubble_cnt;

    // Priority decode: stall holds everything; flush clears all groups;
    // bubble clears only control (and valid), keeping data/addr for the trace
    assign w_load_en    = ~stall_i;
    assign w_ctrl_clr   = flush_i | bubble_i;
    assign w_bubble_evt = ~stall_i & (flush_i | bubble_i);

    assign w_ctrl_d = '{alu_op:     ALUOp_i,
                        alu_src:    ALUSrc_i,
                        mem_read:   MemRead_i,
                        mem_write:  MemWrite_i,
                        reg_write:  RegWrite_i,
                        mem_to_reg: MemtoReg_i};

    // valid shares the control group so control is zero whenever valid is zero
    pipe_field_reg #(.W(CTRLV_W)) u_ctrl_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_load_en),
        .clr_i (w_ctrl_clr),
        .d_i   ({1'b1, w_ctrl_d}),
        .q_o   (w_ctrlv_q)
    );

    pipe_field_reg #(.W(DATAG_W)) u_data_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_load_en),
        .clr_i (flush_i),
        .d_i   ({RS1data_i, RS2data_i, imm_i, funct_i}),
        .q_o   (w_data_q)
    );

    pipe_field_reg #(.W(ADDRG_W)) u_addr_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_load_en),
        .clr_i (flush_i),
        .d_i   ({RS1addr_i, RS2addr_i, RDaddr_i}),
        .q_o   (w_addr_q)
    );

    // Saturating count of inserted bubbles; flush+bubble together count once
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble_evt && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign w_ctrl_q = ctrl_t'(w_ctrlv_q[CTRL_W-1:0]);
    assign valid_o  = w_ctrlv_q[CTRL_W];

    assign ALUOp_o    = w_ctrl_q.alu_op;
    assign ALUSrc_o   = w_ctrl_q.alu_src;
    assign MemRead_o  = w_ctrl_q.mem_read;
    assign MemWrite_o = w_ctrl_q.mem_write;
    assign RegWrite_o = w_ctrl_q.reg_write;
    assign MemtoReg_o = w_ctrl_q.mem_to_reg;

    assign {RS1data_o, RS2data_o, imm_o, funct_o} = w_data_q;
    assign {RS1addr_o, RS2addr_o, RDaddr_o}       = w_addr_q;
    assign bubble_cnt_o                           = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: table-driven vectors with a scoreboard queue,
// plus hand sequences for async reset mid-stall and counter saturation.
module tb_id_ex_pipe_reg;

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 2;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src, mem_read, mem_write, reg_write, mem_to_reg;
    } tctrl_t;

    typedef struct packed {
        tctrl_t        c;
        logic [DW-1:0] rs1, rs2, imm;
        logic [9:0]    funct;
        logic [4:0]    a1, a2, rd;
    } fld_t;

    typedef struct packed {
        fld_t          f;
        logic          valid;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        string         name;
        logic          stall, flush, bubble;
        fld_t          in;
        logic          exp_valid;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, rst2_n;
    logic stall, flush, bubble;
    logic stall2, flush2, bubble2;
    fld_t din;

    fld_t           f1, f2;
    logic           valid1, valid2;
    logic [CW-1:0]  cnt1;
    logic [CW2-1:0] cnt2;
    obs_t           obs1;

    int total = 0;
    int bad   = 0;
    obs_t model;
    obs_t sbq[$];
    int   sbq2[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .stall_i(stall), .flush_i(flush), .bubble_i(bubble),
        .ALUOp_i(din.c.alu_op), .ALUSrc_i(din.c.alu_src), .MemRead_i(din.c.mem_read),
        .MemWrite_i(din.c.mem_write), .RegWrite_i(din.c.reg_write), .MemtoReg_i(din.c.mem_to_reg),
        .RS1data_i(din.rs1), .RS2data_i(din.rs2), .imm_i(din.imm), .funct_i(din.funct),
        .RS1addr_i(din.a1), .RS2addr_i(din.a2), .RDaddr_i(din.rd),
        .ALUOp_o(f1.c.alu_op), .ALUSrc_o(f1.c.alu_src), .MemRead_o(f1.c.mem_read),
        .MemWrite_o(f1.c.mem_write), .RegWrite_o(f1.c.reg_write), .MemtoReg_o(f1.c.mem_to_reg),
        .RS1data_o(f1.rs1), .RS2data_o(f1.rs2), .imm_o(f1.imm), .funct_o(f1.funct),
        .RS1addr_o(f1.a1), .RS2addr_o(f1.a2), .RDaddr_o(f1.rd),
        .valid_o(valid1), .bubble_cnt_o(cnt1)
    );

    id_ex_pipe_reg #(.DATA_W(DW), .CNT_W(CW2)) dut_sat (
        .clk_i(clk), .rst_i(rst2_n),
        .stall_i(stall2), .flush_i(flush2), .bubble_i(bubble2),
        .ALUOp_i(din.c.alu_op), .ALUSrc_i(din.c.alu_src), .MemRead_i(din.c.mem_read),
        .MemWrite_i(din.c.mem_write), .RegWrite_i(din.c.reg_write), .MemtoReg_i(din.c.mem_to_reg),
        .RS1data_i(din.rs1), .RS2data_i(din.rs2), .imm_i(din.imm), .funct_i(din.funct),
        .RS1addr_i(din.a1), .RS2addr_i(din.a2), .RDaddr_i(din.rd),
        .ALUOp_o(f2.c.alu_op), .ALUSrc_o(f2.c.alu_src), .MemRead_o(f2.c.mem_read),
        .MemWrite_o(f2.c.mem_write), .RegWrite_o(f2.c.reg_write), .MemtoReg_o(f2.c.mem_to_reg),
        .RS1data_o(f2.rs1), .RS2data_o(f2.rs2), .imm_o(f2.imm), .funct_o(f2.funct),
        .RS1addr_o(f2.a1), .RS2addr_o(f2.a2), .RDaddr_o(f2.rd),
        .valid_o(valid2), .bubble_cnt_o(cnt2)
    );

    assign obs1 = {f1, valid1, cnt1};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_obs(input string nm, input obs_t a, input obs_t e);
        chk({nm, ":ctrl"},  128'(a.f.c), 128'(e.f.c));
        chk({nm, ":data"},  128'({a.f.rs1, a.f.rs2, a.f.imm, a.f.funct}),
                            128'({e.f.rs1, e.f.rs2, e.f.imm, e.f.funct}));
        chk({nm, ":addr"},  128'({a.f.a1, a.f.a2, a.f.rd}), 128'({e.f.a1, e.f.a2, e.f.rd}));
        chk({nm, ":valid"}, 128'(a.valid), 128'(e.valid));
        chk({nm, ":cnt"},   128'(a.cnt), 128'(e.cnt));
    endtask

    // Behavioural reference of one clock edge for the main instance
    task automatic model_step(input logic s, input logic f, input logic b, input fld_t in);
        if (!s) begin
            if (f) begin
                model.f     = '0;
                model.valid = 1'b0;
            end else if (b) begin
                model.f     = in;
                model.f.c   = '0;
                model.valid = 1'b0;
            end else begin
                model.f     = in;
                model.valid = 1'b1;
            end
            if ((f || b) && model.cnt != {CW{1'b1}}) model.cnt = model.cnt + 1'b1;
        end
    endtask

    // Drive one cycle at the falling edge, score it after the next rising edge
    task automatic drive_and_check(input string nm, input logic s, input logic f,
                                   input logic b, input fld_t in);
        obs_t e;
        @(negedge clk);
        stall = s; flush = f; bubble = b; din = in;
        model_step(s, f, b, in);
        sbq.push_back(model);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({nm, ":sbq_empty"}, 128'(1), 128'(0));
        end else begin
            e = sbq.pop_front();
            cmp_obs(nm, obs1, e);
        end
    endtask

    function automatic fld_t mk(input logic [6:0] c, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] im, input logic [9:0] fn,
                                input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] xd);
        fld_t t;
        t.c = c; t.rs1 = r1; t.rs2 = r2; t.imm = im; t.funct = fn;
        t.a1 = x1; t.a2 = x2; t.rd = xd;
        return t;
    endfunction

    function automatic vec_t mv(input string nm, input logic s, input logic f, input logic b,
                                input fld_t in, input logic ev, input logic [CW-1:0] ec);
        vec_t v;
        v.name = nm; v.stall = s; v.flush = f; v.bubble = b; v.in = in;
        v.exp_valid = ev; v.exp_cnt = ec;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e2;
        fld_t rnd;

        // {inputs, expected valid, expected bubble count}
        vecs[0]  = mv("load_zero",   0, 0, 0, mk(7'h00, 32'h0, 32'h0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0), 1, 0);
        vecs[1]  = mv("load_t2",     0, 0, 0, mk(7'b1000010, 32'h1234, 32'h0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd5), 1, 0);
        vecs[2]  = mv("stall_1",     1, 0, 0, mk(7'h7f, 32'haaaa_5555, 32'h1111_2222, 32'h3333_4444, 10'h155, 5'd1, 5'd2, 5'd3), 1, 0);
        vecs[3]  = mv("stall_flush", 1, 1, 0, mk(7'h15, 32'h5555_aaaa, 32'h2222_1111, 32'h4444_3333, 10'h2aa, 5'd4, 5'd5, 5'd6), 1, 0);
        vecs[4]  = mv("stall_3",     1, 0, 0, mk(7'h6a, 32'hcafe_0001, 32'hcafe_0002, 32'hcafe_0003, 10'h3ff, 5'd31, 5'd30, 5'd29), 1, 0);
        vecs[5]  = mv("bubble_t4",   0, 0, 1, mk(7'b0001000, 32'hdead_beef, 32'h0bad_f00d, 32'hffff_fff0, 10'h2a5, 5'd3, 5'd7, 5'd9), 0, 1);
        vecs[6]  = mv("flush_bub",   0, 1, 1, mk(7'h7f, 32'h8000_0001, 32'h7fff_ffff, 32'h0000_0800, 10'h1c3, 5'd11, 5'd12, 5'd13), 0, 2);
        vecs[7]  = mv("flush",       0, 1, 0, mk(7'h3c, 32'h0123_4567, 32'h89ab_cdef, 32'hfedc_ba98, 10'h0f0, 5'd14, 5'd15, 5'd16), 0, 3);
        vecs[8]  = mv("load_mix",    0, 0, 0, mk(7'b1100101, 32'h1357_9bdf, 32'h2468_ace0, 32'hffff_f800, 10'h207, 5'd17, 5'd18, 5'd19), 1, 3);
        vecs[9]  = mv("stall_bub",   1, 0, 1, mk(7'h7f, 32'h0, 32'h1, 32'h2, 10'h3, 5'd20, 5'd21, 5'd22), 1, 3);
        vecs[10] = mv("bubble_ones", 0, 0, 1, mk(7'h7f, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 10'h3ff, 5'd31, 5'd31, 5'd31), 0, 4);
        vecs[11] = mv("load_final",  0, 0, 0, mk(7'b0110011, 32'h0000_00a5, 32'h0000_005a, 32'h0000_0010, 10'h033, 5'd8, 5'd9, 5'd10), 1, 4);

        // Reset with every input high: outputs must be zero before any edge
        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b1; flush = 1'b1; bubble = 1'b1;
        stall2 = 1'b1; flush2 = 1'b1; bubble2 = 1'b1;
        din = '1;
        model = '0;
        #3;
        cmp_obs("reset", obs1, model);
        chk("reset_sat", 128'({f2, valid2, cnt2}), 128'(0));
        @(posedge clk);
        #1;
        cmp_obs("reset_edge", obs1, model);

        // Release reset with controls low; nothing changes until an edge
        @(negedge clk);
        din = '0; stall = 1'b0; flush = 1'b0; bubble = 1'b0;
        stall2 = 1'b0; flush2 = 1'b0; bubble2 = 1'b0;
        rst_n = 1'b1; rst2_n = 1'b1;
        #1;
        cmp_obs("release", obs1, model);

        for (int i = 0; i < 12; i++) begin
            drive_and_check(vecs[i].name, vecs[i].stall, vecs[i].flush, vecs[i].bubble, vecs[i].in);
            chk({vecs[i].name, ":tbl_valid"}, 128'(valid1), 128'(vecs[i].exp_valid));
            chk({vecs[i].name, ":tbl_cnt"},   128'(cnt1),   128'(vecs[i].exp_cnt));
        end
        chk("t2_rs1", 128'(vecs[1].in.rs1), 128'(32'h1234));

        // Async reset asserted mid-stall clears outputs without a clock edge
        rnd = mk(7'($urandom), $urandom, $urandom, $urandom, 10'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom));
        drive_and_check("stall_pre_rst", 1'b1, 1'b0, 1'b0, rnd);
        #2;
        rst_n = 1'b0;
        model = '0;
        #1;
        cmp_obs("rst_mid_stall", obs1, model);
        @(negedge clk);
        rst_n = 1'b1;
        drive_and_check("post_rst_flush", 1'b0, 1'b1, 1'b0, rnd);
        drive_and_check("post_rst_load",  1'b0, 1'b0, 1'b0, rnd);

        // Narrow counter saturates at 3 after five bubbles
        e2 = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bubble2 = 1'b1;
            din = mk(7'b0001000, 32'h0, 32'h0, 32'h0, 10'h0, 5'd0, 5'd7, 5'd0);
            e2 = (e2 < 3) ? e2 + 1 : 3;
            sbq2.push_back(e2);
            @(posedge clk);
            #1;
            chk("sat_cnt", 128'(cnt2), 128'(sbq2.pop_front()));
            chk("sat_memread", 128'(f2.c.mem_read), 128'(0));
        end
        chk("sat_rs2addr", 128'(f2.a2), 128'(7));
        @(negedge clk);
        bubble2 = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_hold_cnt", 128'(cnt2), 128'(3));
        chk("sat_valid",    128'(valid2), 128'(1));

        // Reset pulse mid-stall on the narrow instance
        @(negedge clk);
        stall2 = 1'b1;
        #2;
        rst2_n = 1'b0;
        #1;
        chk("sat_rst_cnt",   128'(cnt2), 128'(0));
        chk("sat_rst_all",   128'({f2, valid2}), 128'(0));
        #2;
        rst2_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
